// File: rtl/sr_input_pkg.sv
// Shared constants and types for the SR flop input-conditioning slice.
// Optional build macro: SR_CONFLICT_BLOCK_EN (see sr_button_pulse_gen).
package sr_input_pkg;

    localparam int DEFAULT_STABLE_COUNT = 1000000;
    localparam int DEFAULT_CNT_WIDTH    = 20;
    localparam int SIM_STABLE_COUNT     = 4;

    // One debounced channel as seen by the top level
    typedef struct packed {
        logic level;
        logic rise;
    } deb_t;

endpackage

// File: rtl/debounce_core.sv
// Two-flop synchroniser, stability counter and debounced level for one button.
// rise is the strobe for the edge at which level will switch from 0 to 1.
module debounce_core
    import sr_input_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 flip;

    assign flip = (sync2 != level) && (cnt == LAST);
    // Lets the top register its pulse on the same edge the level rises
    assign rise = flip & ~level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_button_pulse_gen.sv
// Debounced set/reset buttons to one-cycle S/R pulses for the SR flop.
// SR_CONFLICT_BLOCK_EN: simultaneous rises give conflict=1 instead of S.
module sr_button_pulse_gen
    import sr_input_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic set_level,
    output logic reset_level,
    output logic conflict
);

    deb_t ch_set;
    deb_t ch_rst;
    logic s_nxt;
    logic r_nxt;
    logic c_nxt;

    debounce_core #(
        .STABLE_COUNT (STABLE_COUNT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_set (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_set),
        .level (ch_set.level),
        .rise  (ch_set.rise)
    );

    debounce_core #(
        .STABLE_COUNT (STABLE_COUNT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_reset),
        .level (ch_rst.level),
        .rise  (ch_rst.rise)
    );

    assign set_level   = ch_set.level;
    assign reset_level = ch_rst.level;

    always_comb begin
        s_nxt = ch_set.rise;
        r_nxt = ch_rst.rise & ~ch_set.rise;
        c_nxt = 1'b0;
`ifdef SR_CONFLICT_BLOCK_EN
        // Both rising together: leave the flop alone and flag it
        if (ch_set.rise && ch_rst.rise) begin
            s_nxt = 1'b0;
            c_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S        <= s_nxt;
            R        <= r_nxt;
            conflict <= c_nxt;
        end
    end

endmodule
